// File: rtl/comb_default_regbank_pkg.sv
// Shared types for the multi-channel register bank: command opcodes, FSM states and
// the channel-index width helper.
package comb_default_regbank_pkg;

    typedef enum logic [1:0] {
        OpClear = 2'd0,
        OpLoad  = 2'd1,
        OpFill  = 2'd2,
        OpInc   = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StFill = 2'd1,
        StDone = 2'd2
    } state_e;

    function automatic int unsigned ch_width(input int unsigned nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/comb_default_regbank_chan.sv
// One bank channel: a WIDTH-bit value plus a written-since-clear flag, updated by a
// clear/load/increment command when we_i is high.
module comb_default_regbank_chan
    import comb_default_regbank_pkg::*;
#(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] DEFAULT = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  op_e              op_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] q_o,
    output logic             vld_o
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             vld_q, vld_d;

    always_comb begin
        q_d   = q_q;
        vld_d = vld_q;
        if (we_i) begin
            unique case (op_i)
                OpClear: begin
                    q_d   = DEFAULT;
                    vld_d = 1'b0;
                end
                OpLoad: begin
                    q_d   = data_i;
                    vld_d = 1'b1;
                end
                OpInc:   q_d = q_q + 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q   <= DEFAULT;
            vld_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            vld_q <= vld_d;
        end
    end

    assign q_o   = q_q;
    assign vld_o = vld_q;

endmodule

// File: rtl/comb_default_regbank.sv
// Bank of NCH registers behind a valid/ready command port; FILL walks every channel
// with one write per cycle and pulses done at the end.
module comb_default_regbank
    import comb_default_regbank_pkg::*;
#(
    parameter int unsigned      NCH     = 4,
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] DEFAULT = '0,
    localparam int unsigned     CW      = ch_width(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [1:0]           cmd_op_i,
    input  logic [CW-1:0]        cmd_ch_i,
    input  logic [WIDTH-1:0]     cmd_data_i,
    output logic [NCH*WIDTH-1:0] q_o,
    output logic [NCH-1:0]       q_vld_o,
    output logic                 done_o,
    output logic                 err_o
);

    state_e           state_q, state_d;
    logic [CW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] fill_q, fill_d;
    logic             err_q, err_d;
    logic             done_q, done_d;

    op_e              op;
    logic             accept;
    logic             ch_ok;
    logic [NCH-1:0]   we;
    op_e              wr_op;
    logic [WIDTH-1:0] wr_data;

    assign op          = op_e'(cmd_op_i);
    assign cmd_ready_o = (state_q == StIdle);
    assign accept      = cmd_valid_i && cmd_ready_o;
    // Out-of-range indices exist only when NCH is not a power of two.
    assign ch_ok       = 32'(cmd_ch_i) < NCH;

    always_comb begin
        we      = '0;
        wr_op   = OpLoad;
        wr_data = fill_q;
        if (state_q == StFill) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (idx_q == CW'(i)) we[i] = 1'b1;
            end
        end else if (accept && (op != OpFill) && ch_ok) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (cmd_ch_i == CW'(i)) we[i] = 1'b1;
            end
            wr_op   = op;
            wr_data = cmd_data_i;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        fill_d  = fill_q;
        err_d   = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (op == OpFill) begin
                        state_d = StFill;
                        idx_d   = '0;
                        fill_d  = cmd_data_i;
                    end else if (!ch_ok) begin
                        err_d = 1'b1;
                    end
                end
            end
            StFill: begin
                idx_d = idx_q + CW'(1);
                if (idx_q == CW'(NCH - 1)) begin
                    state_d = StDone;
                    idx_d   = '0;
                    done_d  = 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            fill_q  <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            fill_q  <= fill_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign err_o  = err_q;
    assign done_o = done_q;

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        comb_default_regbank_chan #(
            .WIDTH   (WIDTH),
            .DEFAULT (DEFAULT)
        ) u_chan (
            .clk    (clk),
            .rst_n  (rst_n),
            .we_i   (we[g]),
            .op_i   (wr_op),
            .data_i (wr_data),
            .q_o    (q_o[g*WIDTH +: WIDTH]),
            .vld_o  (q_vld_o[g])
        );
    end

endmodule

// File: tb/tb_comb_default_regbank.sv
// Directed plus random checks of the register bank against an array model of the
// channel values and flags; a second NCH=3 instance covers out-of-range channels.
module tb_comb_default_regbank;

    localparam int          NCH  = 4;
    localparam int          W    = 8;
    localparam int          NCH3 = 3;
    localparam logic [7:0]  DEF3 = 8'h5A;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        valid = 1'b0;
    logic [1:0]  op    = 2'd0;
    logic [1:0]  ch    = 2'd0;
    logic [7:0]  data  = 8'd0;
    logic        ready, done, err;
    logic [31:0] q;
    logic [3:0]  vld;

    logic        valid3 = 1'b0;
    logic [1:0]  op3    = 2'd0;
    logic [1:0]  ch3    = 2'd0;
    logic [7:0]  data3  = 8'd0;
    logic        ready3, done3, err3;
    logic [23:0] q3;
    logic [2:0]  vld3;

    comb_default_regbank #(
        .NCH     (NCH),
        .WIDTH   (W),
        .DEFAULT (8'h00)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid_i (valid),
        .cmd_ready_o (ready),
        .cmd_op_i    (op),
        .cmd_ch_i    (ch),
        .cmd_data_i  (data),
        .q_o         (q),
        .q_vld_o     (vld),
        .done_o      (done),
        .err_o       (err)
    );

    comb_default_regbank #(
        .NCH     (NCH3),
        .WIDTH   (W),
        .DEFAULT (DEF3)
    ) dut3 (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid_i (valid3),
        .cmd_ready_o (ready3),
        .cmd_op_i    (op3),
        .cmd_ch_i    (ch3),
        .cmd_data_i  (data3),
        .q_o         (q3),
        .q_vld_o     (vld3),
        .done_o      (done3),
        .err_o       (err3)
    );

    // Reference bank for the NCH=4 instance (DEFAULT = 0).
    logic [7:0] m_q   [NCH];
    bit         m_vld [NCH];

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_pack_q();
        logic [31:0] v;
        for (int i = 0; i < NCH; i++) v[i*8 +: 8] = m_q[i];
        return v;
    endfunction

    function automatic logic [3:0] m_pack_vld();
        logic [3:0] v;
        for (int i = 0; i < NCH; i++) v[i] = m_vld[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_q[i]   = 8'h00;
            m_vld[i] = 1'b0;
        end
    endtask

    task automatic model_cmd(input int o, input int c, input logic [7:0] d);
        if (c < NCH) begin
            case (o)
                0: begin m_q[c] = 8'h00; m_vld[c] = 1'b0; end
                1: begin m_q[c] = d;     m_vld[c] = 1'b1; end
                3: m_q[c] = 8'((int'(m_q[c]) + 1) % 256);
                default: ;
            endcase
        end
    endtask

    task automatic check_bank(input string tag, input bit e_ready, input bit e_done,
                              input bit e_err);
        check({tag, ".q"},     q,     m_pack_q());
        check({tag, ".vld"},   vld,   m_pack_vld());
        check({tag, ".ready"}, ready, e_ready);
        check({tag, ".done"},  done,  e_done);
        check({tag, ".err"},   err,   e_err);
    endtask

    task automatic issue(input int o, input int c, input logic [7:0] d, input string tag);
        valid = 1'b1;
        op    = 2'(o);
        ch    = 2'(c);
        data  = d;
        @(posedge clk); #1;
        valid = 1'b0;
        model_cmd(o, c, d);
        check_bank(tag, 1'b1, 1'b0, 1'b0);
    endtask

    // Accepts a FILL; with intrude set, a LOAD is held on the port while busy.
    task automatic fill(input logic [7:0] d, input bit intrude, input string tag);
        valid = 1'b1;
        op    = 2'd2;
        data  = d;
        @(posedge clk); #1;
        if (intrude) begin
            op   = 2'd1;
            ch   = 2'd0;
            data = 8'h77;
        end else begin
            valid = 1'b0;
        end
        check_bank({tag, ".acc"}, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < NCH; k++) begin
            @(posedge clk); #1;
            m_q[k]   = d;
            m_vld[k] = 1'b1;
            check_bank($sformatf("%s.w%0d", tag, k), 1'b0, k == NCH - 1, 1'b0);
        end
        @(posedge clk); #1;
        valid = 1'b0;
        check_bank({tag, ".end"}, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_bank("reset", 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_bank("idle", 1'b1, 1'b0, 1'b0);

        issue(1, 2, 8'hA5, "load_ch2");
        check("load_ch2.exact", q, 32'h00A5_0000);
        issue(1, 1, 8'hFF, "load_ch1");
        issue(3, 1, 8'h00, "inc_wrap");
        check("inc_wrap.ch1", q[15:8], 8'h00);
        check("inc_wrap.vld1", vld[1], 1'b1);

        fill(8'h3C, 1'b1, "fill3c");
        check("fill3c.exact", q, 32'h3C3C_3C3C);

        // Reset two writes into a FILL.
        valid = 1'b1;
        op    = 2'd2;
        data  = 8'h5A;
        @(posedge clk); #1;
        valid = 1'b0;
        issue_wait: for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            m_q[k]   = 8'h5A;
            m_vld[k] = 1'b1;
        end
        check_bank("mid_fill", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_bank("rst_mid", 1'b1, 1'b0, 1'b0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_bank("after_rst", 1'b1, 1'b0, 1'b0);

        issue(1, 0, 8'h11, "load_ch0");
        issue(0, 0, 8'h00, "clear_ch0");
        check("clear_ch0.vld0", vld[0], 1'b0);

        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 7) == 0) begin
                fill(8'($urandom), 1'($urandom_range(0, 1)), "rnd_fill");
            end else begin
                int sel;
                sel = int'($urandom_range(0, 2));
                issue((sel == 0) ? 0 : (sel == 1) ? 1 : 3, int'($urandom_range(0, 3)),
                      8'($urandom), "rnd_cmd");
            end
        end

        // NCH=3 instance with a non-zero DEFAULT.
        check("n3.reset_q", q3, {3{DEF3}});
        check("n3.reset_vld", vld3, 3'b000);
        valid3 = 1'b1;
        op3    = 2'd1;
        ch3    = 2'd3;
        data3  = 8'h99;
        @(posedge clk); #1;
        valid3 = 1'b0;
        check("n3.bad_err", err3, 1'b1);
        check("n3.bad_q", q3, {3{DEF3}});
        check("n3.bad_vld", vld3, 3'b000);
        check("n3.bad_ready", ready3, 1'b1);
        @(posedge clk); #1;
        check("n3.err_pulse", err3, 1'b0);

        valid3 = 1'b1;
        ch3    = 2'd1;
        data3  = 8'h42;
        @(posedge clk); #1;
        op3 = 2'd0;
        @(posedge clk); #1;
        valid3 = 1'b0;
        check("n3.clear_q", q3, {3{DEF3}});
        check("n3.clear_vld", vld3, 3'b000);
        check("n3.clear_err", err3, 1'b0);

        valid3 = 1'b1;
        op3    = 2'd2;
        ch3    = 2'd3;
        data3  = 8'hE1;
        @(posedge clk); #1;
        valid3 = 1'b0;
        check("n3.fill_err", err3, 1'b0);
        check("n3.fill_ready", ready3, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("n3.fill_done", done3, 1'b1);
        check("n3.fill_q", q3, 24'hE1E1E1);
        check("n3.fill_vld", vld3, 3'b111);
        @(posedge clk); #1;
        check("n3.fill_end_ready", ready3, 1'b1);
        check("n3.fill_end_done", done3, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
